// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan of a two-digit seven-segment
// display with blanking gaps between digits and double-buffered digit loads.
// Right digit drives a0 and the left digit drives a1. The cathode bus is shared.
// All drive signals are active-low.
// Optional feature macro: SEG_HEX_DECODE_EN. When it is defined, values 10-15
// decode as A..F. When it is undefined, values 10-15 blank the cathodes.
module seg_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit0_value,
    input  logic [3:0] digit1_value,
    input  logic [1:0] digit_enable,
    output logic       a0,
    output logic       a1,
    output logic [6:0] cathode,
    output logic       frame_tick
);

    localparam int unsigned LP_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned LP_CW  = $clog2(LP_MAX + 1);
    localparam logic [LP_CW-1:0] LP_DIG_LAST = LP_CW'(REFRESH_DIV - 1);
    // With no blanking, BLANK1 is only the post-reset state and leaves after one cycle.
    localparam logic [LP_CW-1:0] LP_BLK_LAST = (BLANK_CYCLES == 0) ? '0 : LP_CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_DIGIT0 = 2'd0,
        S_BLANK0 = 2'd1,
        S_DIGIT1 = 2'd2,
        S_BLANK1 = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LP_CW-1:0] r_cnt;
    logic             w_last;
    logic             w_boundary;

    logic [3:0] r_pend_val0, r_pend_val1, r_act_val0, r_act_val1;
    logic [1:0] r_pend_en, r_act_en;
    logic [3:0] w_act_val0_nxt, w_act_val1_nxt;
    logic [1:0] w_act_en_nxt;

    logic       r_a0, r_a1, r_frame_tick;
    logic [6:0] r_cathode;
    logic       w_a0_nxt, w_a1_nxt;
    logic [6:0] w_cathode_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
`ifdef SEG_HEX_DECODE_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            4'd15:   s = 7'b0111000;
`endif
            default: s = '1;
        endcase
        return s;
    endfunction

    // Next state, frame boundary, next active buffer and next output drive.
    always_comb begin
        w_last         = 1'b0;
        w_next_state   = r_state;
        w_act_val0_nxt = r_act_val0;
        w_act_val1_nxt = r_act_val1;
        w_act_en_nxt   = r_act_en;
        w_a0_nxt       = 1'b1;
        w_a1_nxt       = 1'b1;
        w_cathode_nxt  = '1;

        case (r_state)
            S_DIGIT0, S_DIGIT1: w_last = (r_cnt == LP_DIG_LAST);
            default:            w_last = (r_cnt == LP_BLK_LAST);
        endcase

        if (w_last) begin
            case (r_state)
                S_DIGIT0: w_next_state = (BLANK_CYCLES == 0) ? S_DIGIT1 : S_BLANK0;
                S_BLANK0: w_next_state = S_DIGIT1;
                S_DIGIT1: w_next_state = (BLANK_CYCLES == 0) ? S_DIGIT0 : S_BLANK1;
                default:  w_next_state = S_DIGIT0;
            endcase
        end

        w_boundary = (w_next_state == S_DIGIT0) && (r_state != S_DIGIT0);

        // A load on the boundary edge bypasses pending straight into active.
        if (w_boundary) begin
            w_act_val0_nxt = load ? digit0_value : r_pend_val0;
            w_act_val1_nxt = load ? digit1_value : r_pend_val1;
            w_act_en_nxt   = load ? digit_enable : r_pend_en;
        end

        case (w_next_state)
            S_DIGIT0: begin
                if (w_act_en_nxt[0]) begin
                    w_a0_nxt      = 1'b0;
                    w_cathode_nxt = seg7(w_act_val0_nxt);
                end
            end
            S_DIGIT1: begin
                if (w_act_en_nxt[1]) begin
                    w_a1_nxt      = 1'b0;
                    w_cathode_nxt = seg7(w_act_val1_nxt);
                end
            end
            default: ;
        endcase
    end

    // State register and the per-state cycle counter, which clears on every state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_BLANK1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + LP_CW'(1);
        end
    end

    // Pending and active digit buffers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_val0 <= '0;
            r_pend_val1 <= '0;
            r_pend_en   <= '0;
            r_act_val0  <= '0;
            r_act_val1  <= '0;
            r_act_en    <= '0;
        end else begin
            if (load) begin
                r_pend_val0 <= digit0_value;
                r_pend_val1 <= digit1_value;
                r_pend_en   <= digit_enable;
            end
            r_act_val0 <= w_act_val0_nxt;
            r_act_val1 <= w_act_val1_nxt;
            r_act_en   <= w_act_en_nxt;
        end
    end

    // Registered display drive, updated on the same edge that enters a state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a0         <= 1'b1;
            r_a1         <= 1'b1;
            r_cathode    <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_a0         <= w_a0_nxt;
            r_a1         <= w_a1_nxt;
            r_cathode    <= w_cathode_nxt;
            r_frame_tick <= w_boundary;
        end
    end

    assign a0         = r_a0;
    assign a1         = r_a1;
    assign cathode    = r_cathode;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Testbench for seg_scan_controller. Two instances are run from shared stimulus.
// Instance A uses REFRESH_DIV=4 and BLANK_CYCLES=2. Instance B uses REFRESH_DIV=3
// and BLANK_CYCLES=0, so it has no blanking gaps.
// A frame-position model predicts every output cycle by cycle.
// Literal expectations pin that model at chosen points.
module tb_seg_scan_controller;

    localparam int RA = 4;
    localparam int BA = 2;
    localparam int RB = 3;
    localparam int BB = 0;
`ifdef SEG_HEX_DECODE_EN
    localparam logic [6:0] HEX_B = 7'b1100000;
`else
    localparam logic [6:0] HEX_B = 7'b1111111;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    logic [3:0] d0    = '0;
    logic [3:0] d1    = '0;
    logic [1:0] en    = '0;
    logic       a0_a, a1_a, tick_a, a0_b, a1_b, tick_b;
    logic [6:0] cat_a, cat_b;

    int n_checks = 0;
    int n_err    = 0;

    // Model state.
    // ms[k] counts the clock edges since reset release for instance k.
    int         ms [2];
    logic [3:0] mp0, mp1;
    logic [1:0] mpe;
    logic [3:0] ma0 [2];
    logic [3:0] ma1 [2];
    logic [1:0] mae [2];

    seg_scan_controller #(.REFRESH_DIV(RA), .BLANK_CYCLES(BA)) u_dut_a (
        .clock(clock), .reset(reset), .load(load), .digit0_value(d0), .digit1_value(d1),
        .digit_enable(en), .a0(a0_a), .a1(a1_a), .cathode(cat_a), .frame_tick(tick_a)
    );

    seg_scan_controller #(.REFRESH_DIV(RB), .BLANK_CYCLES(BB)) u_dut_b (
        .clock(clock), .reset(reset), .load(load), .digit0_value(d0), .digit1_value(d1),
        .digit_enable(en), .a0(a0_b), .a1(a1_b), .cathode(cat_b), .frame_tick(tick_b)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
`ifdef SEG_HEX_DECODE_EN
              7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`else
              7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        return t[v];
    endfunction

    function automatic int par_r(input int k);
        return (k == 0) ? RA : RB;
    endfunction

    function automatic int par_b(input int k);
        return (k == 0) ? BA : BB;
    endfunction

    // Frame position after s edges. The value -1 means the initial post-reset blank.
    function automatic int frame_pos(input int s, input int r, input int b);
        int init;
        init = (b > 0) ? b : 1;
        if (s < init) return -1;
        return (s - init) % (2 * r + 2 * b);
    endfunction

    // Returns the expected output vector {a0, a1, cathode, frame_tick}.
    function automatic logic [9:0] model_out(input int s, input int r, input int b,
                                             input logic [3:0] v0, input logic [3:0] v1,
                                             input logic [1:0] e);
        int         p;
        logic       xa0, xa1;
        logic [6:0] c;
        xa0 = 1'b1;
        xa1 = 1'b1;
        c   = 7'h7F;
        p   = frame_pos(s, r, b);
        if (p < 0) return {1'b1, 1'b1, 7'h7F, 1'b0};
        if (p < r) begin
            if (e[0]) begin xa0 = 1'b0; c = seg_ref(v0); end
        end else if (p >= r + b && p < 2 * r + b) begin
            if (e[1]) begin xa1 = 1'b0; c = seg_ref(v1); end
        end
        return {xa0, xa1, c, (p == 0)};
    endfunction

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Model advance. It mirrors the asynchronous reset and the clock edge.
    initial begin
        ms[0] = 0; ms[1] = 0; mp0 = '0; mp1 = '0; mpe = '0;
        for (int k = 0; k < 2; k++) begin ma0[k] = '0; ma1[k] = '0; mae[k] = '0; end
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mp0 = '0; mp1 = '0; mpe = '0;
                for (int k = 0; k < 2; k++) begin
                    ms[k] = 0; ma0[k] = '0; ma1[k] = '0; mae[k] = '0;
                end
            end else begin
                if (load) begin mp0 = d0; mp1 = d1; mpe = en; end
                for (int k = 0; k < 2; k++) begin
                    ms[k] = ms[k] + 1;
                    if (frame_pos(ms[k], par_r(k), par_b(k)) == 0) begin
                        ma0[k] = mp0; ma1[k] = mp1; mae[k] = mpe;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("dutA_out", {a0_a, a1_a, cat_a, tick_a},
                model_out(ms[0], RA, BA, ma0[0], ma1[0], mae[0]));
            chk("dutB_out", {a0_b, a1_b, cat_b, tick_b},
                model_out(ms[1], RB, BB, ma0[1], ma1[1], mae[1]));
            chk("dutA_anode_excl", {9'b0, a0_a | a1_a}, 10'd1);
            chk("dutB_anode_excl", {9'b0, a0_b | a1_b}, 10'd1);
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_phase(input int want);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_pos(ms[0], RA, BA) == want) begin hit = 1'b1; break; end
            tick_n(1);
        end
        if (!hit) begin
            n_checks++; n_err++;
            $display("FAIL wait_phase: timed out at p=%0d, required p=%0d", frame_pos(ms[0], RA, BA), want);
        end
    endtask

    task automatic wait_tick_a();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tick_a === 1'b1) begin hit = 1'b1; break; end
            tick_n(1);
        end
        if (!hit) begin
            n_checks++; n_err++;
            $display("FAIL wait_frame_tick: got no tick within 40 cycles, required one");
        end
    endtask

    // Stimulus, with the literal expectations that pin the model.
    initial begin
        tick_n(2);
        // Test 1: release reset with a load of 2/1 and both digits enabled.
        reset = 1'b0; load = 1'b1; d0 = 4'd1; d1 = 4'd2; en = 2'b11;
        tick_n(1);
        load = 1'b0;
        tick_n(1);
        chk("lit_first_digit0", {a0_a, a1_a, cat_a, tick_a}, {1'b0, 1'b1, 7'b1001111, 1'b1});
        tick_n(4);
        chk("lit_blank0", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b1, 7'b1111111, 1'b0});
        tick_n(2);
        chk("lit_digit1", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b0, 7'b0010010, 1'b0});
        chk("lit_noblank_d0", {a0_b, a1_b, cat_b, tick_b}, {1'b0, 1'b1, 7'b1001111, 1'b0});
        tick_n(16);

        // Test 2: a load in mid DIGIT1 is held in pending until the next frame.
        wait_phase(7);
        load = 1'b1; d0 = 4'd3; d1 = 4'd7;
        tick_n(1);
        load = 1'b0;
        chk("lit_midframe_old", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b0, 7'b0010010, 1'b0});
        wait_tick_a();
        chk("lit_after_tick_new", {a0_a, a1_a, cat_a, tick_a}, {1'b0, 1'b1, 7'b0000110, 1'b1});

        // Test 3: a load on the boundary edge bypasses into active.
        wait_phase(11);
        load = 1'b1; d0 = 4'd5;
        tick_n(1);
        load = 1'b0;
        chk("lit_bypass", {a0_a, a1_a, cat_a, tick_a}, {1'b0, 1'b1, 7'b0100100, 1'b1});

        // Test 4: only the right digit is enabled.
        load = 1'b1; d0 = 4'd8; d1 = 4'd9; en = 2'b01;
        tick_n(1);
        load = 1'b0;
        wait_phase(0);
        wait_phase(7);
        chk("lit_left_disabled", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b1, 7'b1111111, 1'b0});

        // Test 6: the value 4'hB, then a reset in mid DIGIT0.
        load = 1'b1; d0 = 4'hB; en = 2'b11;
        tick_n(1);
        load = 1'b0;
        wait_phase(0);
        wait_phase(1);
        chk("lit_hex_b", {a0_a, a1_a, cat_a, tick_a}, {1'b0, 1'b1, HEX_B, 1'b0});
        #1 reset = 1'b1;
        #1;
        chk("lit_async_reset", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b1, 7'b1111111, 1'b0});
        tick_n(2);
        reset = 1'b0;
        tick_n(30);
        chk("lit_blank_after_reset", {a0_a, a1_a, cat_a, tick_a}, {1'b1, 1'b1, 7'b1111111, 1'b0});

        // Randomized loads, values and enables.
        repeat (400) begin
            load = ($urandom_range(0, 3) == 0);
            d0   = 4'($urandom_range(0, 15));
            d1   = 4'($urandom_range(0, 15));
            en   = 2'($urandom_range(0, 3));
            tick_n(1);
        end
        load = 1'b0;
        tick_n(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
